// File: rtl/cond_unit_if.sv
// Decoder/ALU-to-condition-unit bundle: instruction request and flags in,
// gated write enables, architectural flags and overflow count out.
interface cond_unit_if #(
    parameter int unsigned CNT_W = 8
);
    logic             valid_in;
    logic             stall;
    logic [3:0]       Cond;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic [3:0]       ALUFlags;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             valid_out;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output valid_in, stall, Cond, FlagW, PCS, RegW, MemW, ALUFlags,
        input  CondEx, PCSrc, RegWrite, MemWrite, valid_out, Flags, ovf_count
    );

    modport slave (
        input  valid_in, stall, Cond, FlagW, PCS, RegW, MemW, ALUFlags,
        output CondEx, PCSrc, RegWrite, MemWrite, valid_out, Flags, ovf_count
    );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: holds N/Z/C/V, evaluates the condition field, registers the
// gated PC/register/memory write requests and counts overflow events.
module cond_unit #(
    parameter int unsigned CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    cond_unit_if.slave bus
);
    logic [3:0]       flags;
    logic [CNT_W-1:0] cnt;
    logic             condex;
    logic             pcsrc, regwrite, memwrite, valid_q;
    logic             n, z, c, v;

    assign {n, z, c, v} = flags;

    // Evaluated against registered flags only; no bypass from ALUFlags.
    always_comb begin
        condex = 1'b0;
        unique case (bus.Cond)
            4'b0000: condex = z;
            4'b0001: condex = !z;
            4'b0010: condex = c;
            4'b0011: condex = !c;
            4'b0100: condex = n;
            4'b0101: condex = !n;
            4'b0110: condex = v;
            4'b0111: condex = !v;
            4'b1000: condex = c & !z;
            4'b1001: condex = !c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = !z & (n == v);
            4'b1101: condex = z | (n != v);
            default: condex = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags    <= '0;
            cnt      <= '0;
            pcsrc    <= 1'b0;
            regwrite <= 1'b0;
            memwrite <= 1'b0;
            valid_q  <= 1'b0;
        end else if (!bus.stall) begin
            valid_q  <= bus.valid_in;
            pcsrc    <= bus.valid_in & condex & bus.PCS;
            regwrite <= bus.valid_in & condex & bus.RegW;
            memwrite <= bus.valid_in & condex & bus.MemW;
            if (bus.valid_in && condex) begin
                if (bus.FlagW[1]) flags[3:2] <= bus.ALUFlags[3:2];
                if (bus.FlagW[0]) flags[1:0] <= bus.ALUFlags[1:0];
                if (bus.FlagW[0] && bus.ALUFlags[0] && cnt != '1)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.CondEx    = condex;
    assign bus.PCSrc     = pcsrc;
    assign bus.RegWrite  = regwrite;
    assign bus.MemWrite  = memwrite;
    assign bus.valid_out = valid_q;
    assign bus.Flags     = flags;
    assign bus.ovf_count = cnt;
endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the flag/condition rules.
module tb_cond_unit;
    localparam int unsigned CNT_W = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cond_unit_if #(.CNT_W(CNT_W)) bus ();

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model state
    bit       started = 0;
    bit [3:0] m_flags;
    int       m_cnt;
    bit       m_vo, m_pc, m_rw, m_mw;

    // ARM-style: pairs of conditions share a base test, odd codes invert it.
    function automatic bit mcond(input logic [3:0] cc, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: return 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_flags = 4'b0000;
            m_cnt = 0;
            {m_vo, m_pc, m_rw, m_mw} = 4'b0000;
        end else if (started && !bus.stall) begin
            bit ex;
            ex   = bus.valid_in && mcond(bus.Cond, m_flags);
            m_vo = bus.valid_in;
            m_pc = ex && bus.PCS;
            m_rw = ex && bus.RegW;
            m_mw = ex && bus.MemW;
            if (ex) begin
                if (bus.FlagW[1]) begin
                    m_flags[3] = bus.ALUFlags[3];
                    m_flags[2] = bus.ALUFlags[2];
                end
                if (bus.FlagW[0]) begin
                    m_flags[1] = bus.ALUFlags[1];
                    m_flags[0] = bus.ALUFlags[0];
                    if (bus.ALUFlags[0]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                end
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("CondEx",    32'(bus.CondEx),    32'(mcond(bus.Cond, m_flags)));
            chk("valid_out", 32'(bus.valid_out), 32'(m_vo));
            chk("PCSrc",     32'(bus.PCSrc),     32'(m_pc));
            chk("RegWrite",  32'(bus.RegWrite),  32'(m_rw));
            chk("MemWrite",  32'(bus.MemWrite),  32'(m_mw));
            chk("Flags",     32'(bus.Flags),     32'(m_flags));
            chk("ovf_count", 32'(bus.ovf_count), 32'(m_cnt));
        end
    end

    task automatic set(input bit r, input bit v, input bit st, input logic [3:0] cc,
                       input logic [1:0] fw, input bit p, input bit rw, input bit mw,
                       input logic [3:0] alu);
        rst = r; bus.valid_in = v; bus.stall = st; bus.Cond = cc; bus.FlagW = fw;
        bus.PCS = p; bus.RegW = rw; bus.MemW = mw; bus.ALUFlags = alu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set(1, 0, 0, 4'h0, 2'b00, 0, 0, 0, 4'h0);
        step(); step();

        // Reset state
        set(0, 1, 0, 4'b0000, 2'b00, 0, 1, 0, 4'h0);
        chk("rst_flags", 32'(bus.Flags), 32'h0);
        chk("rst_vo", 32'(bus.valid_out), 32'h0);
        chk("rst_cnt", 32'(bus.ovf_count), 32'h0);
        #1 chk("eq_on_zero", 32'(bus.CondEx), 32'h0);
        step();
        chk("noexec_vo", 32'(bus.valid_out), 32'h1);
        chk("noexec_rw", 32'(bus.RegWrite), 32'h0);

        // AL sets Z, then EQ passes
        set(0, 1, 0, 4'b1110, 2'b11, 0, 1, 0, 4'b0100);
        step();
        chk("al_flags", 32'(bus.Flags), 32'h4);
        chk("al_rw", 32'(bus.RegWrite), 32'h1);
        set(0, 1, 0, 4'b0000, 2'b00, 0, 0, 0, 4'h0);
        #1 chk("eq_after_z", 32'(bus.CondEx), 32'h1);
        step();

        // N=1,V=0: GE fails, LT executes
        set(0, 1, 0, 4'b1110, 2'b11, 0, 0, 0, 4'b1000);
        step();
        chk("n_flags", 32'(bus.Flags), 32'h8);
        set(0, 1, 0, 4'b1010, 2'b11, 1, 1, 1, 4'b0001);
        #1 chk("ge_fail", 32'(bus.CondEx), 32'h0);
        step();
        chk("ge_flags_hold", 32'(bus.Flags), 32'h8);
        chk("ge_no_write", 32'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'h0);
        chk("ge_cnt", 32'(bus.ovf_count), 32'h0);
        set(0, 1, 0, 4'b1011, 2'b00, 0, 1, 1, 4'h0);
        #1 chk("lt_pass", 32'(bus.CondEx), 32'h1);
        step();
        chk("lt_write", 32'({bus.RegWrite, bus.MemWrite}), 32'h3);

        // FlagW=01 only touches C,V
        set(0, 1, 0, 4'b1110, 2'b11, 0, 0, 0, 4'b0000);
        step();
        set(0, 1, 0, 4'b1110, 2'b01, 0, 0, 0, 4'b1111);
        step();
        chk("cv_only", 32'(bus.Flags), 32'h3);

        // Overflow counting, stall freeze, saturation
        set(1, 0, 0, 4'h0, 2'b00, 0, 0, 0, 4'h0);
        step();
        set(0, 1, 0, 4'b1110, 2'b01, 0, 1, 0, 4'b0001);
        step();
        chk("ovf_1", 32'(bus.ovf_count), 32'h1);
        set(0, 1, 1, 4'b1110, 2'b01, 0, 0, 0, 4'b0001);
        step(); step();
        chk("stall_cnt", 32'(bus.ovf_count), 32'h1);
        chk("stall_flags", 32'(bus.Flags), 32'h1);
        chk("stall_rw_hold", 32'(bus.RegWrite), 32'h1);
        set(0, 1, 0, 4'b1110, 2'b01, 0, 1, 0, 4'b0001);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("ovf_sat", 32'(bus.ovf_count), 32'((i > 3) ? 3 : i));
        end

        // Reset discards in-flight instruction
        set(1, 1, 0, 4'b1110, 2'b11, 1, 1, 1, 4'b1111);
        step();
        set(0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 4'h0);
        chk("midrst_out", 32'({bus.valid_out, bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'h0);
        chk("midrst_flags", 32'(bus.Flags), 32'h0);
        chk("midrst_cnt", 32'(bus.ovf_count), 32'h0);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            set($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0, 4'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            step();
        end

        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
